// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: N-approach signal phase sequencer.
// One approach at a time owns green, then a fixed yellow and all-red clearance precede the
// next approach. Green dwell is demand-actuated between GREEN_MIN and GREEN_MAX cycles,
// empty approaches are skipped round-robin, and an emergency pre-empt forces a target.
module traffic_phase_controller #(
  parameter int unsigned N         = 4,
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 16,
  parameter int unsigned YELLOW    = 2,
  parameter int unsigned ALLRED    = 1,
  localparam int unsigned IW       = $clog2(N),
  localparam int unsigned TMAX_GY  = (GREEN_MAX > YELLOW) ? GREEN_MAX : YELLOW,
  localparam int unsigned TMAX     = (TMAX_GY > ALLRED) ? TMAX_GY : ALLRED,
  localparam int unsigned CW       = $clog2(TMAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    car,
  input  logic            preempt,
  input  logic [IW-1:0]   preempt_idx,
  output logic [2*N-1:0]  lights,
  output logic [IW-1:0]   active,
  output logic [1:0]      phase
);

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10
  } state_e;

  localparam logic [CW-1:0] GMinM1   = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMaxM1   = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YellowM1 = CW'(YELLOW - 1);
  localparam logic [CW-1:0] AllRedM1 = CW'(ALLRED - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   active_q, active_d;
  logic [IW-1:0]   nxt_q, nxt_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]    other;
  logic [IW-1:0]   cand;
  logic            cand_found;
  logic            pre_valid;
  logic            pre_switch;
  logic            gap_out;
  logic            max_out;

  // Demand on approaches other than the owner, and the next one round-robin after the owner.
  always_comb begin
    logic [IW-1:0] idx;
    other             = car;
    other[active_q]   = 1'b0;
    cand              = active_q;
    cand_found        = 1'b0;
    idx               = '0;
    for (int unsigned k = 1; k < N; k++) begin
      idx = IW'((32'(active_q) + k) % N);
      if (!cand_found && other[idx]) begin
        cand       = idx;
        cand_found = 1'b1;
      end
    end
  end

  // Green-phase termination conditions; a pre-empt naming the owner suppresses both timers.
  always_comb begin
    pre_valid  = preempt && (32'(preempt_idx) < N);
    pre_switch = pre_valid && (preempt_idx != active_q);
    gap_out    = !pre_valid && (other != '0) && (cnt_q >= GMinM1) && !car[active_q];
    max_out    = !pre_valid && (other != '0) && (cnt_q == GMaxM1);
  end

  // Phase sequencing and dwell timer next-state.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    nxt_d    = nxt_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StGreen: begin
        if (pre_switch) begin
          state_d = StYellow;
          nxt_d   = preempt_idx;
          cnt_d   = '0;
        end else if (gap_out || max_out) begin
          state_d = StYellow;
          nxt_d   = cand;
          cnt_d   = '0;
        end else if (cnt_q != GMaxM1) begin
          // Saturate so max-out remains armed while the owner keeps green.
          cnt_d = cnt_q + CW'(1);
        end
      end
      StYellow: begin
        if (cnt_q == YellowM1) begin
          state_d = StAllRed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StAllRed: begin
        if (cnt_q == AllRedM1) begin
          state_d  = StGreen;
          active_d = nxt_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StGreen;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset to approach 0 green.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StGreen;
      active_q <= '0;
      nxt_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      nxt_q    <= nxt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Moore lamp decode: only the owner may be non-red, and never during all-red.
  always_comb begin
    lights = {N{2'b10}};
    unique case (state_q)
      StGreen:  lights[{active_q, 1'b0} +: 2] = 2'b00;
      StYellow: lights[{active_q, 1'b0} +: 2] = 2'b01;
      default:  lights = {N{2'b10}};
    endcase
    active = active_q;
    phase  = state_q;
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with N=4 and default timing parameters.
module tb_traffic_phase_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] car;
  logic       preempt;
  logic [1:0] preempt_idx;
  logic [7:0] lights;
  logic [1:0] active;
  logic [1:0] phase;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  traffic_phase_controller #(
    .N         (4),
    .GREEN_MIN (4),
    .GREEN_MAX (16),
    .YELLOW    (2),
    .ALLRED    (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .car         (car),
    .preempt     (preempt),
    .preempt_idx (preempt_idx),
    .lights      (lights),
    .active      (active),
    .phase       (phase)
  );

  // Expected {lights, active, phase} for a given phase code and owner.
  function automatic logic [11:0] expv(input logic [1:0] ph, input logic [1:0] act);
    logic [7:0] l;
    l = 8'b10101010;
    if (ph == 2'b00) l[act*2 +: 2] = 2'b00;
    else if (ph == 2'b01) l[act*2 +: 2] = 2'b01;
    return {l, act, ph};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    car         = '0;
    preempt     = 1'b0;
    preempt_idx = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    car         = 4'b1111;
    preempt     = 1'b0;
    preempt_idx = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({lights, active, phase} !== {8'b10101000, 2'd0, 2'b00}) begin
        $display("FAIL reset_state cyc %0d: got %b/%0d/%b want 10101000/0/00",
                 i, lights, active, phase);
        fails++;
      end
    end
    reset = 1'b0;
    car   = 4'b0000;
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({lights, active, phase} !== {8'b10101000, 2'd0, 2'b00}) begin
        $display("FAIL reset_hold cyc %0d: got %b/%0d/%b want 10101000/0/00",
                 c, lights, active, phase);
        fails++;
      end
      step();
    end
  endtask

  task automatic test_gap_out();
    logic [11:0] e;
    do_reset();
    car = 4'b0100;
    for (int c = 0; c <= 12; c++) begin
      if (c <= 3)      e = expv(2'b00, 2'd0);
      else if (c <= 5) e = expv(2'b01, 2'd0);
      else if (c == 6) e = expv(2'b10, 2'd0);
      else             e = expv(2'b00, 2'd2);
      checks++;
      if ({lights, active, phase} !== e) begin
        $display("FAIL gap_out cyc %0d: got %b want %b", c, {lights, active, phase}, e);
        fails++;
      end
      step();
    end
  endtask

  task automatic test_max_out();
    logic [11:0] e;
    do_reset();
    car = 4'b0101;
    for (int c = 0; c <= 45; c++) begin
      if (c <= 15)      e = expv(2'b00, 2'd0);
      else if (c <= 17) e = expv(2'b01, 2'd0);
      else if (c == 18) e = expv(2'b10, 2'd0);
      else if (c <= 34) e = expv(2'b00, 2'd2);
      else if (c <= 36) e = expv(2'b01, 2'd2);
      else if (c == 37) e = expv(2'b10, 2'd2);
      else              e = expv(2'b00, 2'd0);
      checks++;
      if ({lights, active, phase} !== e) begin
        $display("FAIL max_out cyc %0d: got %b want %b", c, {lights, active, phase}, e);
        fails++;
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] e;
    do_reset();
    car = 4'b1000;
    for (int c = 0; c <= 50; c++) begin
      if (c == 7) car = 4'b1011;
      if (c <= 3)       e = expv(2'b00, 2'd0);
      else if (c <= 5)  e = expv(2'b01, 2'd0);
      else if (c == 6)  e = expv(2'b10, 2'd0);
      else if (c <= 22) e = expv(2'b00, 2'd3);
      else if (c <= 24) e = expv(2'b01, 2'd3);
      else if (c == 25) e = expv(2'b10, 2'd3);
      else if (c <= 41) e = expv(2'b00, 2'd0);
      else if (c <= 43) e = expv(2'b01, 2'd0);
      else if (c == 44) e = expv(2'b10, 2'd0);
      else              e = expv(2'b00, 2'd1);
      checks++;
      if ({lights, active, phase} !== e) begin
        $display("FAIL round_robin cyc %0d: got %b want %b", c, {lights, active, phase}, e);
        fails++;
      end
      step();
    end
  endtask

  task automatic test_preempt();
    logic [11:0] e;
    do_reset();
    car = 4'b0001;
    for (int c = 0; c <= 36; c++) begin
      if (c == 1) begin
        preempt     = 1'b1;
        preempt_idx = 2'd3;
      end
      if (c == 30) preempt = 1'b0;
      if (c <= 1)       e = expv(2'b00, 2'd0);
      else if (c <= 3)  e = expv(2'b01, 2'd0);
      else if (c == 4)  e = expv(2'b10, 2'd0);
      else if (c <= 30) e = expv(2'b00, 2'd3);
      else if (c <= 32) e = expv(2'b01, 2'd3);
      else if (c == 33) e = expv(2'b10, 2'd3);
      else              e = expv(2'b00, 2'd0);
      checks++;
      if ({lights, active, phase} !== e) begin
        $display("FAIL preempt cyc %0d: got %b want %b", c, {lights, active, phase}, e);
        fails++;
      end
      step();
    end
    preempt     = 1'b0;
    preempt_idx = '0;
  endtask

  task automatic test_late_demand();
    logic [11:0] e;
    do_reset();
    car = 4'b0000;
    for (int c = 0; c <= 16; c++) begin
      if (c == 10) car = 4'b0010;
      if (c <= 10)      e = expv(2'b00, 2'd0);
      else if (c <= 12) e = expv(2'b01, 2'd0);
      else if (c == 13) e = expv(2'b10, 2'd0);
      else              e = expv(2'b00, 2'd1);
      checks++;
      if ({lights, active, phase} !== e) begin
        $display("FAIL late_demand cyc %0d: got %b want %b", c, {lights, active, phase}, e);
        fails++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] e;
    do_reset();
    car = 4'b0100;
    for (int c = 0; c < 4; c++) step();
    checks++;
    if ({lights, active, phase} !== expv(2'b01, 2'd0)) begin
      $display("FAIL reset_mid_pre: got %b want %b", {lights, active, phase},
               expv(2'b01, 2'd0));
      fails++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      if (c <= 3)      e = expv(2'b00, 2'd0);
      else if (c <= 5) e = expv(2'b01, 2'd0);
      else if (c == 6) e = expv(2'b10, 2'd0);
      else             e = expv(2'b00, 2'd2);
      checks++;
      if ({lights, active, phase} !== e) begin
        $display("FAIL reset_mid cyc %0d: got %b want %b", c, {lights, active, phase}, e);
        fails++;
      end
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    car         = '0;
    preempt     = 1'b0;
    preempt_idx = '0;
    #1;
    test_reset();
    test_gap_out();
    test_max_out();
    test_round_robin();
    test_preempt();
    test_late_demand();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
